// File: rtl/bcd3_to_bin8.sv
// Three-digit BCD to 8-bit binary converter (reverse double-dabble, one bit per cycle).
// Out-of-range input (digit > 9 or value > 255) short-circuits to DONE with err set.
module bcd3_to_bin8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [19:0] work, work_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [7:0]  bin_nx;
  logic        err_nx;
  logic        invalid;
  logic [19:0] shifted, adjusted;

  // hundreds > 2 already covers an out-of-range hundreds digit
  always_comb begin
    invalid = (hundreds > 4'd2) || (tens > 4'd9) || (ones > 4'd9) ||
              ((hundreds == 4'd2) && ((tens > 4'd5) ||
                                      ((tens == 4'd5) && (ones > 4'd5))));
  end

  // One reverse double-dabble step: shift right, then pull each BCD digit >= 8 back by 3
  always_comb begin
    shifted  = {1'b0, work[19:1]};
    adjusted = shifted;
    for (int unsigned d = 0; d < 3; d++) begin
      if (shifted[8 + 4*d + 3]) begin
        adjusted[8 + 4*d +: 4] = shifted[8 + 4*d +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_nx = state;
    work_nx  = work;
    cnt_nx   = cnt;
    bin_nx   = bin;
    err_nx   = err;
    case (state)
      IDLE: begin
        if (start) begin
          work_nx = {hundreds, tens, ones, 8'h00};
          cnt_nx  = '0;
          if (invalid) begin
            state_nx = DONE;
            bin_nx   = '0;
            err_nx   = 1'b1;
          end else begin
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_nx = adjusted;
        cnt_nx  = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_nx = DONE;
          bin_nx   = adjusted[7:0];
          err_nx   = 1'b0;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      bin   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      work  <= work_nx;
      cnt   <= cnt_nx;
      bin   <= bin_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_bcd3_to_bin8.sv
// Scoreboard bench for bcd3_to_bin8: stimulus pushes expected {err,bin}; a monitor
// pops and compares on every done pulse. Directed timing checks sit alongside.
module tb_bcd3_to_bin8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] hundreds, tens, ones;
  logic [7:0] bin;
  logic       busy, done, err;

  always #5 clk = ~clk;

  bcd3_to_bin8 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  logic [8:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with bin=%0h err=%0b, expected no done (cycle %0d)",
                 bin, err, cyc);
      end else begin
        logic [8:0] e;
        e = expq.pop_front();
        chk("bin", {24'd0, bin}, {24'd0, e[7:0]});
        chk("err", {31'd0, err}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // One conversion: checks done latency and busy width; value checked by monitor
  task automatic run(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                     input logic [7:0] eb, input logic ee);
    int lat = 0;
    int busy_n = 0;
    int d0;
    int k;
    wait_idle();
    d0 = done_cnt;
    start = 1'b1; hundreds = h; tens = t; ones = o;
    expq.push_back({ee, eb});
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        hundreds = 4'($urandom); tens = 4'($urandom); ones = 4'($urandom);
      end
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1 && lat == 0) lat = k;
    end while (busy !== 1'b0 && k < 40);
    chk("latency", lat, ee ? 32'd1 : 32'd9);
    chk("busy_cycles", busy_n, ee ? 32'd1 : 32'd9);
    chk("done_pulses", done_cnt - d0, 32'd1);
  endtask

  initial begin
    int t_first, t_second, d0, k, v;
    rst = 1'b1; start = 1'b0; hundreds = '0; tens = '0; ones = '0;
    repeat (2) @(negedge clk);
    chk("rst_bin", {24'd0, bin}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Maximum representable value
    run(4'd2, 4'd5, 4'd5, 8'hFF, 1'b0);

    // Back-to-back with start held high: 000 then 128
    wait_idle();
    d0 = done_cnt; t_first = -1; t_second = -1;
    start = 1'b1; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
    expq.push_back({1'b0, 8'h00});
    expq.push_back({1'b0, 8'h80});
    @(negedge clk);
    hundreds = 4'd1; tens = 4'd2; ones = 4'd8;
    k = 0;
    while (t_second < 0 && k < 40) begin
      if (done === 1'b1) begin
        if (t_first < 0) t_first = cyc; else t_second = cyc;
      end
      if (t_second < 0) @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("b2b_gap", t_second - t_first, 32'd10);
    wait_idle();
    chk("b2b_pulses", done_cnt - d0, 32'd2);

    // Invalid digit, overflow, then a valid conversion clears err
    run(4'd1, 4'hA, 4'd3, 8'h00, 1'b1);
    run(4'd2, 4'd5, 4'd6, 8'h00, 1'b1);
    run(4'd0, 4'd0, 4'd7, 8'h07, 1'b0);

    // Start during SHIFT is ignored
    wait_idle();
    d0 = done_cnt;
    start = 1'b1; hundreds = 4'd0; tens = 4'd9; ones = 4'd9;
    expq.push_back({1'b0, 8'h63});
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; hundreds = 4'd2; tens = 4'd0; ones = 4'd0;
    @(negedge clk); start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    chk("ignored_start_pulses", done_cnt - d0, 32'd1);

    // Reset during the 4th SHIFT cycle aborts without a done pulse
    wait_idle();
    d0 = done_cnt;
    start = 1'b1; hundreds = 4'd1; tens = 4'd0; ones = 4'd0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bin", {24'd0, bin}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_pulses", done_cnt - d0, 32'd0);
    run(4'd0, 4'd4, 4'd2, 8'h2A, 1'b0);

    // All 1000 digit triples
    for (int h = 0; h < 10; h++)
      for (int t = 0; t < 10; t++)
        for (int o = 0; o < 10; o++) begin
          v = 100*h + 10*t + o;
          run(4'(h), 4'(t), 4'(o), (v <= 255) ? 8'(v) : 8'h00, (v > 255));
        end

    repeat (3) @(negedge clk);
    chk("queue_empty", expq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd3_to_bin8.md
BCD3_TO_BIN8 -- requirements
Module: bcd3_to_bin8

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 hundreds  input  4  BCD hundreds digit; sampled with start.
REQ-006 tens  input  4  BCD tens digit; sampled with start.
REQ-007 ones  input  4  BCD ones digit; sampled with start.
REQ-008 bin  output  8  binary result; registered; holds the last result until the next done.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; marks bin and err as updated.
REQ-011 err  output  1  registered error flag for the last conversion; updated with done.

Function
REQ-012 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at edge E0:
- capture the digits into a 12-bit BCD field of a 20-bit work register {bcd[11:0], acc[7:0]}, with acc=0;
- clear the 3-bit iteration counter.
REQ-014 Validity check at E0: the input is invalid if any digit exceeds 9, or if the value exceeds 255, meaning:
- hundreds>2; or
- hundreds==2 and tens>5; or
- hundreds==2, tens==5 and ones>5.
REQ-015 Valid input: IDLE goes to SHIFT at E0. Invalid input: IDLE goes directly to DONE at E0, with bin=0 and err=1 loaded.
REQ-016 SHIFT performs one iteration per cycle:
- shift the 20-bit work register right by 1 (bcd[0] enters acc[7]);
- then, for each 4-bit BCD digit of the shifted value that is 8 or more, subtract 3 from that digit (4-bit arithmetic, no borrow between digits);
- increment the counter.
REQ-017 SHIFT SHALL execute exactly 8 iterations, at edges E1..E8. At E8 the state goes to DONE, bin is loaded from acc, and err is cleared to 0.
REQ-018 In DONE, done=1 for exactly one cycle. The state returns to IDLE at the next edge.
REQ-019 Latency: done is visible in the cycle after E8 for valid input, and in the cycle after E0 for invalid input.
REQ-020 busy=1 in SHIFT and DONE and 0 in IDLE. A start in IDLE in the same cycle is sampled, and busy rises in the cycle after E0.
REQ-021 start while busy=1 SHALL be ignored, with no queuing. Digit inputs SHALL be ignored outside the sampling edge.
REQ-022 A start held high continuously SHALL begin a new conversion on each return to IDLE. Back-to-back valid conversions occur every 10 cycles.
REQ-023 bin and err SHALL change only on the edge that enters DONE.
REQ-024 Outputs SHALL be pure functions of registers, with no combinational path from inputs to outputs.

Reset
REQ-025 When rst=1 at a rising edge, the following SHALL be cleared, with priority over all other activity including start: state=IDLE, counter=0, work register=0, bin=0, err=0, done=0, busy=0.
REQ-026 Reset asserted mid-conversion (SHIFT or DONE) SHALL abort the conversion with no done pulse and return all outputs to their reset values in the cycle after the edge.

Verification
REQ-027 Digits 2,5,5 with start -> after 8 SHIFT cycles a single done pulse with bin=0xFF and err=0; busy=1 for exactly 9 cycles.
REQ-028 Digits 0,0,0, then 1,2,8 back-to-back with start held high -> bin=0x00 then 0x80, both with err=0, and the done pulses are 10 cycles apart.
REQ-029 Digits 1,A,3 (invalid digit) and separately 2,5,6 (overflow) -> done in the cycle after the start edge, with bin=0x00 and err=1; the next valid conversion clears err.
REQ-030 Start with 0,9,9; then start pulsed with 2,0,0 during SHIFT -> the second start is ignored, bin=0x63 (99), and no second done pulse occurs.
REQ-031 Start with 1,0,0; rst=1 at the 4th SHIFT cycle -> next cycle busy=0, done=0, bin=0, err=0, and no done pulse follows; a new start with 0,4,2 -> bin=0x2A.
REQ-032 Exhaustive sweep over all 1000 digit triples -> for each triple, bin equals 100h+10t+o when that value is at most 255 (with err=0); otherwise err=1 and bin=0.
